// File: rtl/oldland_bootrom_responder.sv
// rtl/oldland_bootrom_responder.sv - word-addressed read-only memory responder for cache line fills
// Programmable wait states, back-to-back burst accept during the response cycle, backdoor preload port.
module oldland_bootrom_responder #(
    parameter int          MEM_WORDS   = 4096,
    parameter logic [29:0] ADDR_BASE   = 30'h0,
    parameter int          WAIT_STATES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_access,
    input  logic [29:0]                  m_addr,
    output logic [31:0]                  m_data,
    output logic                         m_ack,
    output logic                         m_error,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    // One extra bit so base + size never wraps past the 30-bit address space.
    localparam logic [30:0]       ADDR_END  = {1'b0, ADDR_BASE} + 31'(MEM_WORDS);
    localparam logic [IDX_W-1:0]  BASE_LO   = ADDR_BASE[IDX_W-1:0];
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [3:0]        cnt;
    logic [3:0]        cnt_n;
    logic              accept;
    logic              fire;
    logic              in_range_req;
    logic              in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic [31:0]       mem [MEM_WORDS];

    assign in_range_req = (m_addr >= ADDR_BASE) && ({1'b0, m_addr} < ADDR_END);
    assign fire         = (state == READ) && m_access;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (m_access) begin
                    accept  = 1'b1;
                    cnt_n   = WAIT_INIT;
                    state_n = (WAIT_STATES != 0) ? WAIT : READ;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (!m_access) begin
                    state_n = IDLE;
                end else if (cnt == 4'd1) begin
                    state_n = READ;
                end
            end
            READ: begin
                state_n = m_access ? RESP : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            m_ack    <= 1'b0;
            m_error  <= 1'b0;
            m_data   <= 32'd0;
            in_range <= 1'b0;
            addr_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            m_ack   <= fire && in_range;
            m_error <= fire && !in_range;
            m_data  <= (fire && in_range) ? mem[addr_idx] : 32'd0;
            if (accept) begin
                in_range <= in_range_req;
                addr_idx <= m_addr[IDX_W-1:0] - BASE_LO;
            end
        end
    end

    // Contents survive reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_oldland_bootrom_responder.sv
// tb/tb_oldland_bootrom_responder.sv - scoreboard bench for oldland_bootrom_responder
// Two instances: 4096 words at base 0 with 2 wait states, 64 words at base 0x100 with none.
module tb_oldland_bootrom_responder;

    localparam int          W0 = 2;
    localparam int          W1 = 0;
    localparam int          N0 = 4096;
    localparam int          N1 = 64;
    localparam logic [29:0] B0 = 30'h0;
    localparam logic [29:0] B1 = 30'h100;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc     [2];
    logic [29:0] addr    [2];
    logic [31:0] rdata   [2];
    logic        ack     [2];
    logic        err     [2];
    logic        ld_en   [2];
    logic [31:0] ld_data [2];
    logic [11:0] ld_addr0;
    logic [5:0]  ld_addr1;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          n_resp [2];
    int          n_exp  [2];
    logic        prev_resp [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mdl0 [16];
    logic [31:0] mdl1 [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oldland_bootrom_responder #(.MEM_WORDS(N0), .ADDR_BASE(B0), .WAIT_STATES(W0)) dut0 (
        .clk(clk), .rst(rst), .m_access(acc[0]), .m_addr(addr[0]), .m_data(rdata[0]),
        .m_ack(ack[0]), .m_error(err[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr0), .ld_data(ld_data[0])
    );

    oldland_bootrom_responder #(.MEM_WORDS(N1), .ADDR_BASE(B1), .WAIT_STATES(W1)) dut1 (
        .clk(clk), .rst(rst), .m_access(acc[1]), .m_addr(addr[1]), .m_data(rdata[1]),
        .m_ack(ack[1]), .m_error(err[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr1), .ld_data(ld_data[1])
    );

    function automatic int wst(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic push_exp(input int d, input logic [29:0] a, input int due);
        exp_t   e;
        longint la;
        longint base;
        longint n;
        la    = longint'(a);
        base  = (d == 0) ? longint'(B0) : longint'(B1);
        n     = (d == 0) ? N0 : N1;
        e.due = due;
        if (la >= base && la < base + n) begin
            e.err  = 1'b0;
            e.data = (d == 0) ? mdl0[int'(la - base)] : mdl1[int'(la - base)];
        end else begin
            e.err  = 1'b1;
            e.data = 32'd0;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        n_exp[d]++;
    endtask

    task automatic drop_last(input int d);
        if (d == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        n_exp[d]--;
    endtask

    task automatic check_out(input int d);
        exp_t e;
        int   qs;
        if (ack[d] === 1'b1 || err[d] === 1'b1) begin
            n_resp[d]++;
            total++;
            if (ack[d] && err[d]) begin
                bad++;
                $display("FAIL excl dut%0d: ack=%b err=%b want not both", d, ack[d], err[d]);
            end
            total++;
            if (prev_resp[d]) begin
                bad++;
                $display("FAIL consecutive dut%0d: response at cyc %0d follows one at %0d", d, cyc, cyc - 1);
            end
            qs = (d == 0) ? q0.size() : q1.size();
            total++;
            if (qs == 0) begin
                bad++;
                $display("FAIL unexpected dut%0d: ack=%b err=%b at cyc %0d, want none", d, ack[d], err[d], cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                total++;
                if (ack[d] !== !e.err || err[d] !== e.err) begin
                    bad++;
                    $display("FAIL kind dut%0d: ack=%b err=%b want err=%b", d, ack[d], err[d], e.err);
                end
                total++;
                if (rdata[d] !== e.data) begin
                    bad++;
                    $display("FAIL data dut%0d: got %h want %h", d, rdata[d], e.data);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL timing dut%0d: response at cyc %0d want %0d", d, cyc, e.due);
                end
            end
        end
        prev_resp[d] = (ack[d] === 1'b1) || (err[d] === 1'b1);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_out(d);
    end

    task automatic wait_resp(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL resp_timeout dut%0d: no response in 40 cycles, want one", d);
        end
    endtask

    task automatic backdoor(input int d, input int idx, input logic [31:0] val);
        @(negedge clk);
        ld_en[d]   = 1'b1;
        ld_data[d] = val;
        ld_addr0   = 12'(idx);
        ld_addr1   = 6'(idx);
        @(negedge clk);
        ld_en[d] = 1'b0;
        if (d == 0) mdl0[idx] = val; else mdl1[idx] = val;
    endtask

    // Cache-style burst: next address is presented during each response cycle.
    task automatic run_burst(input int d, input logic [29:0] a [8], input int n,
                             input int drop_idx, input bit hold_extra);
        bit ok;
        bit done;
        int r;
        done = 1'b0;
        @(negedge clk);
        acc[d]  = 1'b1;
        addr[d] = a[0];
        push_exp(d, a[0], cyc + 2 + wst(d));
        for (int i = 0; i < n && !done; i++) begin
            if (i == drop_idx) begin
                r = $urandom_range(0, wst(d));
                repeat (r + 1) @(negedge clk);
                acc[d]  = 1'b0;
                addr[d] = 30'($urandom);
                drop_last(d);
                done = 1'b1;
            end else begin
                wait_resp(d, ok);
                if (!ok) begin
                    acc[d] = 1'b0;
                    drop_last(d);
                    done = 1'b1;
                end else if (i < n - 1) begin
                    addr[d] = a[i + 1];
                    push_exp(d, a[i + 1], cyc + 2 + wst(d));
                end else if (hold_extra) begin
                    addr[d] = 30'($urandom);
                    @(negedge clk);
                    acc[d] = 1'b0;
                end else begin
                    acc[d] = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic single(input int d, input logic [29:0] a0);
        logic [29:0] a [8];
        for (int i = 0; i < 8; i++) a[i] = a0;
        run_burst(d, a, 1, -1, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0; addr[d] = '0; ld_en[d] = 1'b0; ld_data[d] = '0;
            n_resp[d] = 0; n_exp[d] = 0; prev_resp[d] = 1'b0;
        end
        ld_addr0 = '0;
        ld_addr1 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'd0) begin
                bad++;
                $display("FAIL reset_out dut%0d: ack=%b err=%b data=%h want 0 0 0", d, ack[d], err[d], rdata[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_preload;
        for (int i = 0; i < 16; i++) backdoor(0, i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 16; i++) backdoor(1, i, 32'h2000_0000 + 32'(i));
    endtask

    task automatic test_line_fill;
        logic [29:0] a [8];
        int          t0;
        int          r0;
        for (int i = 0; i < 8; i++) a[i] = 30'(i);
        t0 = cyc;
        r0 = n_resp[0];
        run_burst(0, a, 8, -1, 1'b0);
        total++;
        if (n_resp[0] - r0 !== 8) begin
            bad++;
            $display("FAIL line_fill_count: got %0d responses want 8", n_resp[0] - r0);
        end
        total++;
        if (cyc - t0 !== 36) begin
            bad++;
            $display("FAIL line_fill_span: got %0d cycles want 36 (32 + 4 idle)", cyc - t0);
        end
    endtask

    task automatic test_range;
        single(1, 30'h105);
        single(1, 30'h0FF);
        single(1, 30'h100 + 30'(N1));
        single(1, 30'h100);
        single(1, 30'h100 + 30'(N1) - 30'd1 - 30'(N1 - 16));
        single(0, 30'(N0));
        single(0, 30'h3FFF_FFFF);
    endtask

    task automatic test_hold_extra;
        logic [29:0] a [8];
        for (int i = 0; i < 8; i++) a[i] = 30'(7 - i);
        run_burst(0, a, 3, -1, 1'b1);
        single(0, 30'd2);
        for (int i = 0; i < 8; i++) a[i] = 30'h108 + 30'(i);
        run_burst(1, a, 4, -1, 1'b1);
        single(1, 30'h101);
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        acc[0]  = 1'b1;
        addr[0] = 30'd5;
        push_exp(0, 30'd5, cyc + 2 + W0);
        @(negedge clk);
        rst    = 1'b1;
        acc[0] = 1'b0;
        drop_last(0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'd0) begin
                bad++;
                $display("FAIL rst_wait dut%0d: ack=%b err=%b data=%h want 0 0 0", d, ack[d], err[d], rdata[d]);
            end
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        single(0, 30'd5);
    endtask

    task automatic test_same_edge_load;
        bit ok;
        @(negedge clk);
        acc[1]  = 1'b1;
        addr[1] = 30'h103;
        push_exp(1, 30'h103, cyc + 2 + W1);
        @(negedge clk);
        ld_en[1]   = 1'b1;
        ld_addr1   = 6'd3;
        ld_data[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_en[1] = 1'b0;
        mdl1[3]  = 32'hDEAD_BEEF;
        total++;
        if (ack[1] !== 1'b1) begin
            bad++;
            $display("FAIL same_edge_ack: ack=%b want 1", ack[1]);
        end
        push_exp(1, 30'h103, cyc + 2 + W1);
        wait_resp(1, ok);
        acc[1] = 1'b0;
        if (!ok) drop_last(1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        logic [29:0] a [8];
        int          d;
        int          n;
        int          r;
        for (int it = 0; it < 40; it++) begin
            d = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 8)
                    a[i] = ((d == 0) ? B0 : B1) + 30'($urandom_range(0, 15));
                else if (d == 0)
                    a[i] = 30'(N0) + 30'($urandom_range(0, 100));
                else if (r == 8)
                    a[i] = 30'h0FF - 30'($urandom_range(0, 200));
                else
                    a[i] = 30'h100 + 30'(N1) + 30'($urandom_range(0, 100));
            end
            run_burst(d, a, n, int'($urandom_range(0, 2 * n)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_line_fill();
        test_range();
        test_hold_extra();
        test_reset_in_wait();
        test_same_edge_load();
        test_random();
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (((d == 0) ? q0.size() : q1.size()) != 0) begin
                bad++;
                $display("FAIL leftover dut%0d: %0d expected responses never seen, want 0", d,
                         (d == 0) ? q0.size() : q1.size());
            end
            total++;
            if (n_resp[d] != n_exp[d]) begin
                bad++;
                $display("FAIL resp_count dut%0d: got %0d responses want %0d", d, n_resp[d], n_exp[d]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/oldland_bootrom_responder.md
# oldland_bootrom_responder

Word-addressed, read-only memory responder on the oldland cache↔memory bus: it answers line-fill reads issued by the instruction cache's memory port (`m_access`/`m_addr`/`m_data`/`m_ack`/`m_error`). It models on-chip ROM/SRAM with a programmable number of wait states. A backdoor load port lets the bootloader or testbench preload contents. The block sits between the cache's memory side and the on-chip memory array.

## Interface
- `MEM_WORDS`, 4096: number of 32-bit words; power of two.
- `ADDR_BASE`, 30'h0: word address of word 0; must be `MEM_WORDS`-aligned.
- `WAIT_STATES`, 2: extra cycles inserted before each ack; 0..15.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `m_access` in 1: read request, held high by initiator across a burst.
- `m_addr` in 30: word address; sampled only at request-accept edges.
- `m_data` out 32: read data; valid only while `m_ack` is high.
- `m_ack` out 1: one-cycle pulse; read completed successfully.
- `m_error` out 1: one-cycle pulse; address out of range, replaces `m_ack`.
- `ld_en` in 1: backdoor write strobe.
- `ld_addr` in clog2(MEM_WORDS): backdoor word index, not offset by `ADDR_BASE`.
- `ld_data` in 32: backdoor write data.

## Operation
- States: IDLE, WAIT, READ, RESP.
- IDLE:
  - Edge with `m_access`=1: latch `m_addr`, compute `in_range` = (`addr` >= `ADDR_BASE`) && (`addr` < `ADDR_BASE` + `MEM_WORDS`).
    - 30-bit unsigned compare; no wrap past 2^30.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES` != 0, else READ.
- WAIT: decrement the counter each edge; at 1 → READ.
- READ:
  - Array read at index (`addr` − `ADDR_BASE`)[clog2(MEM_WORDS)-1:0].
  - Next edge → RESP, driving `m_ack`=`in_range`, `m_error`=!`in_range`, `m_data`=word or 0 on error.
- RESP: outputs high for this single cycle. At the edge ending RESP:
  - `m_access`=1: accept a new request (latch `m_addr`) exactly as from IDLE. This is back-to-back burst operation; the initiator presents the next address combinationally during the ack cycle.
  - Otherwise → IDLE.
- Abort: in WAIT or READ, an edge with `m_access`=0 returns to IDLE. No ack or error is ever issued for the abandoned request. The cache holds `m_access` one cycle past its final ack, so a spurious accepted request must die silently.
- `m_ack`/`m_error` are registered, mutually exclusive, and never high for two consecutive cycles.
- Backdoor load: `ld_en` writes the array at the edge, independent of state. A read of the same index at the same edge returns the old data.
- Reset:
  - State → IDLE; `m_ack`=0, `m_error`=0, `m_data`=0, counter=0.
  - An in-flight request is discarded; no ack appears in the cycle after reset.
  - Array contents are preserved.

## Timing
- Request accepted at edge k.
- `m_ack`/`m_error` high during the cycle after edge k+1+`WAIT_STATES`.
- `WAIT_STATES`=0 gives 2-cycle latency, 1 word per 2 cycles in a burst.
- Throughput: one word per `WAIT_STATES`+2 cycles.
- 8-word line fill, `WAIT_STATES`=2: first ack 4 cycles after accept, then every 4 cycles; 32 cycles total.
- `m_addr` changes outside accept edges are ignored.
- `rst` has priority over every event, including a simultaneous accept or `ld_en` state effects. `ld_en` writes still take effect under reset.

## Test plan
- Preload words 0..7 with 0x1000_0000+i via backdoor; `WAIT_STATES`=2; cache-style burst at `m_addr` 0..7, next address shown during each ack → 8 acks spaced 4 cycles, data 0x1000_0000..0x1000_0007, no `m_error`.
- `WAIT_STATES`=0, `ADDR_BASE`=0x100; single read at 0x105 → `m_ack` in 2nd cycle after accept, `m_data`=word 5. Read at 0x0FF and at 0x100+`MEM_WORDS` → `m_error` pulse, `m_data`=0, no `m_ack`.
- Access held one cycle past the last ack, then dropped → no further `m_ack`/`m_error`; state returns to IDLE; next request served normally.
- `rst` asserted while in WAIT → outputs 0 next cycle, no ack ever for that request; the preloaded word is still readable after reset.
- `ld_en` writing 0xDEAD_BEEF to index 3 at the same edge as the READ of index 3 → ack returns old value; an immediate re-read returns 0xDEAD_BEEF.
- Random bursts against a reference model with random `m_access` drops → ack count equals completed requests; `m_ack` and `m_error` never high together or on consecutive cycles.
